time_entry: RTL and testbench

TIME_ENTRY -- requirements
Module: time_entry

---
 rtl/time_entry.sv | 220 ++++++++++++++++++++++
 tb/tb_time_entry.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_entry.sv
// time_entry: four-digit HH:MM entry from BCD switches and two bouncing push-buttons.
//
// Each raw button is synchronized (2 flops), debounced (a level changes only after
// DEBOUNCE_CYCLES equal samples) and edge-detected into a one-cycle press pulse.
// Load presses step an entry FSM through h1, h2, m1, m2. Each digit is range-checked
// before it is staged. A fourth valid digit commits the staged time to h1..m2.
// A cancel press discards the entry in progress.
//
// Optional feature: define TIME_ENTRY_TIMEOUT_EN to abort an entry that stays idle for
// TIMEOUT_CYCLES between load presses. The abort pulses err once.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   load_btn    raw load push-button
//   cancel_btn  raw cancel push-button
//   loadin      BCD digit sampled on an accepted load press
//   h1,h2,m1,m2 committed hours tens/units, minutes tens/units
//   commit      one-cycle pulse, h1..m2 hold a new valid time
//   err         one-cycle pulse, digit rejected (or entry timed out)
//   busy        entry in progress (digit_idx != 0)
//   digit_idx   index of the next digit expected (0=h1 .. 3=m2)
module time_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_btn,
  input  logic       cancel_btn,
  input  logic [3:0] loadin,
  output logic [3:0] h1,
  output logic [3:0] h2,
  output logic [3:0] m1,
  output logic [3:0] m2,
  output logic       commit,
  output logic       err,
  output logic       busy,
  output logic [1:0] digit_idx
);

  localparam int unsigned DbCntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [2:0] {
    StD0  = 3'd0,
    StD1  = 3'd1,
    StD2  = 3'd2,
    StD3  = 3'd3,
    StCmt = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning. Bit 0 is load, bit 1 is cancel.
  // ---------------------------------------------------------------------------
  logic [1:0]        w_raw;
  logic [1:0]        r_sync1;
  logic [1:0]        r_sync2;
  logic [1:0]        r_db;
  logic [1:0]        r_db_d;
  logic [1:0]        r_armed;
  logic [1:0]        r_press;
  logic [1:0]        r_fill;
  logic [DbCntW-1:0] r_db_cnt [2];

  assign w_raw = {cancel_btn, load_btn};

  // r_fill marks when r_sync2 carries a post-reset sample of the pin. A button is armed
  // only after it has been seen released, so a button held through reset stays silent
  // until it is released and pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_db     <= '0;
      r_db_d   <= '0;
      r_armed  <= '0;
      r_press  <= '0;
      r_fill   <= '0;
      for (int b = 0; b < 2; b++) begin
        r_db_cnt[b] <= '0;
      end
    end else begin
      r_fill <= {r_fill[0], 1'b1};
      for (int b = 0; b < 2; b++) begin
        r_sync1[b] <= w_raw[b];
        r_sync2[b] <= r_sync1[b];
        r_db_d[b]  <= r_db[b];
        r_press[b] <= r_db[b] & ~r_db_d[b] & r_armed[b];
        if (r_fill[1] && !r_sync2[b]) begin
          r_armed[b] <= 1'b1;
        end
        if (r_sync2[b] == r_db[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DbCntW'(DEBOUNCE_CYCLES - 1)) begin
          r_db[b]     <= r_sync2[b];
          r_db_cnt[b] <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Entry FSM
  // ---------------------------------------------------------------------------
  state_t          r_state;
  state_t          w_state_d;
  logic [3:0][3:0] r_stg;
  logic [3:0][3:0] w_stg_d;
  logic [3:0][3:0] r_time;
  logic            r_commit;
  logic            r_err;
  logic            w_commit_d;
  logic            w_err_d;
  logic [3:0]      w_limit;
  logic            w_valid;
  logic            w_load;
  logic            w_cancel;
  logic            w_timeout;

  assign digit_idx = (r_state == StCmt) ? 2'd0 : r_state[1:0];
  assign busy      = (digit_idx != 2'd0);
  assign w_load    = r_press[0];
  assign w_cancel  = r_press[1] | w_timeout;

`ifdef TIME_ENTRY_TIMEOUT_EN
  localparam int unsigned ToCntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [ToCntW-1:0] r_to_cnt;

  // Counts idle cycles during an entry. Any load press, accepted or rejected, restarts it.
  assign w_timeout = busy && !w_load && (r_to_cnt == ToCntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !busy || w_load || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Largest legal value for the digit currently expected. 10..15 always exceed it.
  always_comb begin
    w_limit = 4'd9;
    case (r_state)
      StD0:    w_limit = 4'd2;
      StD1:    w_limit = (r_stg[0] == 4'd2) ? 4'd3 : 4'd9;
      StD2:    w_limit = 4'd5;
      default: w_limit = 4'd9;
    endcase
  end

  assign w_valid = (loadin <= w_limit);

  always_comb begin
    w_state_d  = r_state;
    w_stg_d    = r_stg;
    w_commit_d = 1'b0;
    w_err_d    = 1'b0;
    if (r_state == StCmt) begin
      // Loads arriving during the commit cycle are dropped.
      w_state_d = StD0;
    end else if (w_cancel) begin
      // Cancel takes priority over a simultaneous load; in D0 there is nothing to drop.
      if (r_state != StD0) begin
        w_state_d = StD0;
        w_stg_d   = '0;
      end
    end else if (w_load) begin
      if (w_valid) begin
        w_stg_d[r_state[1:0]] = loadin;
        case (r_state)
          StD0:    w_state_d = StD1;
          StD1:    w_state_d = StD2;
          StD2:    w_state_d = StD3;
          default: w_state_d = StCmt;
        endcase
        if (r_state == StD3) begin
          w_commit_d = 1'b1;
        end
      end else begin
        w_err_d = 1'b1;
      end
    end
    if (w_timeout) begin
      w_err_d = 1'b1;
    end
  end

  // commit and the new time become visible together during the CMT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StD0;
      r_stg    <= '0;
      r_time   <= '0;
      r_commit <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_stg    <= w_stg_d;
      r_commit <= w_commit_d;
      r_err    <= w_err_d;
      if (w_commit_d) begin
        r_time <= w_stg_d;
      end
    end
  end

  assign h1     = r_time[0];
  assign h2     = r_time[1];
  assign m1     = r_time[2];
  assign m2     = r_time[3];
  assign commit = r_commit;
  assign err    = r_err;

endmodule

// File: tb/tb_time_entry.sv
// Randomized self-checking bench for time_entry with a press-level reference model.
module tb_time_entry;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Tmo  = 50;
  localparam int          Hold = Deb + 8;

  logic       clk;
  logic       rst;
  logic       load_btn;
  logic       cancel_btn;
  logic [3:0] loadin;
  logic [3:0] h1;
  logic [3:0] h2;
  logic [3:0] m1;
  logic [3:0] m2;
  logic       commit;
  logic       err;
  logic       busy;
  logic [1:0] digit_idx;

  time_entry #(
    .DEBOUNCE_CYCLES(Deb),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_btn  (load_btn),
    .cancel_btn(cancel_btn),
    .loadin    (loadin),
    .h1        (h1),
    .h2        (h2),
    .m1        (m1),
    .m2        (m2),
    .commit    (commit),
    .err       (err),
    .busy      (busy),
    .digit_idx (digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;
  int n_commit;
  int n_err;

  // Reference model: digits entered so far, staged values, committed time.
  int m_idx;
  int m_stg[4];
  int m_h[4];
  int m_ncommit;
  int m_nerr;

  always @(negedge clk) begin
    if (commit) n_commit++;
    if (err) n_err++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int digit_limit();
    case (m_idx)
      0:       return 2;
      1:       return (m_stg[0] == 2) ? 3 : 9;
      2:       return 5;
      default: return 9;
    endcase
  endfunction

  task automatic model_load(input int d);
    if (d <= digit_limit()) begin
      m_stg[m_idx] = d;
      m_idx++;
      if (m_idx == 4) begin
        m_h = m_stg;
        m_ncommit++;
        m_idx = 0;
      end
    end else begin
      m_nerr++;
    end
  endtask

  task automatic model_cancel();
    if (m_idx != 0) begin
      m_idx = 0;
      for (int i = 0; i < 4; i++) m_stg[i] = 0;
    end
  endtask

  task automatic model_reset();
    m_idx = 0;
    for (int i = 0; i < 4; i++) begin
      m_stg[i] = 0;
      m_h[i]   = 0;
    end
  endtask

  task automatic check_state(input string tag);
    int exp_time;
    exp_time = (m_h[0] << 12) | (m_h[1] << 8) | (m_h[2] << 4) | m_h[3];
    check_val({tag, "_idx"}, 32'(digit_idx), 32'(m_idx));
    check_val({tag, "_busy"}, 32'(busy), 32'(m_idx != 0));
    check_val({tag, "_time"}, 32'({h1, h2, m1, m2}), 32'(exp_time));
    check_val({tag, "_ncommit"}, 32'(n_commit), 32'(m_ncommit));
    check_val({tag, "_nerr"}, 32'(n_err), 32'(m_nerr));
  endtask

  // One clean-ish button action with short bounce bursts on press and release.
  task automatic drive_btn(input logic ld, input logic cn, input logic [3:0] d);
    int nb;
    loadin = d;
    nb = $urandom_range(0, 3);
    for (int i = 0; i < nb; i++) begin
      load_btn = ld; cancel_btn = cn;
      @(negedge clk);
      load_btn = 1'b0; cancel_btn = 1'b0;
      @(negedge clk);
    end
    load_btn = ld; cancel_btn = cn;
    repeat (Hold) @(negedge clk);
    nb = $urandom_range(0, 3);
    for (int i = 0; i < nb; i++) begin
      load_btn = 1'b0; cancel_btn = 1'b0;
      @(negedge clk);
      load_btn = ld; cancel_btn = cn;
      @(negedge clk);
    end
    load_btn = 1'b0; cancel_btn = 1'b0;
    repeat (Hold) @(negedge clk);
  endtask

  task automatic do_load(input int d);
    drive_btn(1'b1, 1'b0, 4'(d));
    model_load(d);
  endtask

  task automatic do_cancel();
    drive_btn(1'b0, 1'b1, 4'($urandom_range(0, 15)));
    model_cancel();
  endtask

  task automatic do_both(input int d);
    drive_btn(1'b1, 1'b1, 4'(d));
    model_cancel();
  endtask

  function automatic int pick_digit();
    if ($urandom_range(0, 3) != 0) return $urandom_range(0, digit_limit());
    return $urandom_range(0, 15);
  endfunction

  initial begin
    int lat;
    int op;
    n_vec = 0; n_miss = 0; n_commit = 0; n_err = 0;
    m_ncommit = 0; m_nerr = 0;
    model_reset();
    rst = 1'b1; load_btn = 1'b0; cancel_btn = 1'b0; loadin = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("rst_time", 32'({h1, h2, m1, m2}), 32'd0);
    check_val("rst_commit", 32'(commit), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_idx", 32'(digit_idx), 32'd0);
    repeat (5) @(negedge clk);

    // Basic entry 12:34.
    do_load(1); do_load(2); do_load(3); do_load(4);
    check_state("e1234");

    // Rejected digit leaves index at 1, then 23:59.
    do_load(2); do_load(4);
    check_state("rej");
    do_load(3); do_load(5); do_load(9);
    check_state("e2359");

    // Bouncing load, then held: one press, fixed latency to the FSM step.
    loadin = 4'd1;
    for (int i = 0; i < 10; i++) begin
      load_btn = ~load_btn;
      repeat (2) @(negedge clk);
    end
    load_btn = 1'b1;
    lat = 0;
    while (digit_idx == 2'd0 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("press_lat", 32'(lat), 32'(Deb + 4));
    @(negedge clk);
    repeat (Hold) @(negedge clk);
    load_btn = 1'b0;
    repeat (Hold) @(negedge clk);
    model_load(1);
    check_state("bounce");

    // Digits 1,2 then cancel+load together.
    do_load(2);
    do_both(5);
    check_state("both");

    // Idle after one digit.
    do_load(1);
    repeat (60) @(negedge clk);
`ifdef TIME_ENTRY_TIMEOUT_EN
    model_cancel();
    m_nerr++;
`endif
    check_state("idle");
    do_cancel();
    check_state("cancel");

    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 9);
      if (op < 7) do_load(pick_digit());
      else if (op < 9) do_cancel();
      else do_both(pick_digit());
      check_state("rnd");
    end

    // Reset in D2 with load held through it.
    do_cancel();
    do_load(1); do_load(2);
    check_state("pre_rst");
    loadin = 4'd5;
    rst = 1'b1; load_btn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (30) @(negedge clk);
    check_val("hold_time", 32'({h1, h2, m1, m2}), 32'd0);
    check_val("hold_commit", 32'(commit), 32'd0);
    check_val("hold_err", 32'(err), 32'd0);
    check_state("held");
    load_btn = 1'b0;
    repeat (Hold) @(negedge clk);
    check_state("released");
    do_load(1);
    check_state("repress");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
